// File: rtl/req_merge_pkg.sv
// req_merge_pkg
//   Shared constants and types for the 16:1 cache-line request merger.
//   N_REQ : number of requesters (fixed at 16)
//   GRP   : requesters per first-level arbiter; N_REQ/GRP groups at level 2
//   ID_W  : width of the granted requester ID
//   ptr_t : 2-bit last-grant pointer / index within a 4-wide arbiter
package req_merge_pkg;

   localparam int unsigned N_REQ = 16;
   localparam int unsigned GRP   = 4;
   localparam int unsigned N_GRP = N_REQ / GRP;
   localparam int unsigned ID_W  = 4;

   typedef logic [1:0] ptr_t;

endpackage

// File: rtl/req_merge_rr_arb4.sv
// rr_arb4
//   Combinational 4:1 round-robin arbiter. Scans ptr_i+1 .. ptr_i+4 (mod 4)
//   and picks the first valid input.
//   valid_i : per-input request valid
//   ptr_i   : index of the last granted input
//   gnt_o   : one-hot grant (zero when nothing is valid)
//   idx_o   : index of the granted input (0 when nothing is valid)
//   any_o   : at least one input is valid
module rr_arb4
   import req_merge_pkg::*;
(
   input  logic [3:0] valid_i,
   input  ptr_t       ptr_i,
   output logic [3:0] gnt_o,
   output ptr_t       idx_o,
   output logic       any_o
);

   logic found;
   ptr_t pos;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = '0;
      // 2-bit addition wraps naturally, so k=4 lands back on ptr_i itself
      for (int unsigned k = 1; k <= 4; k++) begin
         pos = ptr_i + ptr_t'(k);
         if (!found && valid_i[pos]) begin
            found      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = pos;
         end
      end
   end

   assign any_o = |valid_i;

endmodule

// File: rtl/req_merge.sv
// req_merge
//   16:1 request merger: four 4:1 round-robin arbiters feed a fifth 4:1
//   round-robin arbiter; the winner ID goes into a one-entry valid/ready
//   output register.
//   clk        : clock, all state updates on posedge
//   reset      : synchronous active-high reset
//   i_clreq_v  : per-requester request valid
//   i_clreq_r  : per-requester grant, one-hot or zero
//   o_v        : output entry valid (registered)
//   o_r        : downstream ready
//   o_clid_req : ID of the granted requester (registered)
module req_merge
   import req_merge_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] i_clreq_v,
   output logic [N_REQ-1:0] i_clreq_r,
   output logic             o_v,
   input  logic             o_r,
   output logic [ID_W-1:0]  o_clid_req
);

   ptr_t            l1_q [N_GRP];
   ptr_t            l1_d [N_GRP];
   ptr_t            l2_q, l2_d;
   logic            o_v_q, o_v_d;
   logic [ID_W-1:0] clid_q, clid_d;

   logic [3:0]      grp_any;
   ptr_t            grp_idx [N_GRP];
   logic [3:0]      grp_gnt [N_GRP];
   logic [3:0]      l2_gnt;
   ptr_t            win_grp;
   logic            any_req;
   logic [ID_W-1:0] win_id;
   logic            accept;
   logic            hs;

   for (genvar g = 0; g < N_GRP; g++) begin : g_l1
      rr_arb4 u_l1 (
         .valid_i (i_clreq_v[GRP*g +: GRP]),
         .ptr_i   (l1_q[g]),
         .gnt_o   (grp_gnt[g]),
         .idx_o   (grp_idx[g]),
         .any_o   (grp_any[g])
      );
   end

   rr_arb4 u_l2 (
      .valid_i (grp_any),
      .ptr_i   (l2_q),
      .gnt_o   (l2_gnt),
      .idx_o   (win_grp),
      .any_o   (any_req)
   );

   assign win_id = {win_grp, grp_idx[win_grp]};
   assign accept = ~o_v_q | o_r;

   // The tree winner is valid by construction, so any_req alone qualifies it
   always_comb begin
      i_clreq_r = '0;
      if (!reset && accept && any_req) begin
         i_clreq_r[win_id] = 1'b1;
      end
   end

   assign hs = |(i_clreq_v & i_clreq_r);

   always_comb begin
      o_v_d  = o_v_q;
      clid_d = clid_q;
      l2_d   = l2_q;
      for (int unsigned g = 0; g < N_GRP; g++) begin
         l1_d[g] = l1_q[g];
      end
      if (accept) begin
         o_v_d = hs;
      end
      if (hs) begin
         clid_d           = win_id;
         l2_d             = win_grp;
         l1_d[win_grp]    = grp_idx[win_grp];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_v_q  <= 1'b0;
         clid_q <= '0;
         l2_q   <= 2'd3;
         for (int unsigned g = 0; g < N_GRP; g++) begin
            l1_q[g] <= 2'd3;
         end
      end else begin
         o_v_q  <= o_v_d;
         clid_q <= clid_d;
         l2_q   <= l2_d;
         for (int unsigned g = 0; g < N_GRP; g++) begin
            l1_q[g] <= l1_d[g];
         end
      end
   end

   assign o_v        = o_v_q;
   assign o_clid_req = clid_q;

endmodule

// File: tb/tb_req_merge.sv
module tb_req_merge;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] i_clreq_v;
   logic [15:0] i_clreq_r;
   logic        o_v;
   logic        o_r;
   logic [3:0]  o_clid_req;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // reference state: pointers as plain integers, output entry
   int          m_l1 [4];
   int          m_l2;
   bit          m_ov;
   int          m_id;
   logic [15:0] obs_gnt;

   always #5 clk = ~clk;

   req_merge dut (
      .clk        (clk),
      .reset      (reset),
      .i_clreq_v  (i_clreq_v),
      .i_clreq_r  (i_clreq_r),
      .o_v        (o_v),
      .o_r        (o_r),
      .o_clid_req (o_clid_req)
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   function automatic void m_reset();
      for (int g = 0; g < 4; g++) m_l1[g] = 3;
      m_l2 = 3;
      m_ov = 1'b0;
      m_id = 0;
   endfunction

   // first valid group after the level-2 pointer, then first valid member
   // after that group's pointer; -1 when nothing is requesting
   function automatic int m_win(input logic [15:0] v);
      int g;
      int i;
      for (int a = 1; a <= 4; a++) begin
         g = (m_l2 + a) % 4;
         for (int b = 1; b <= 4; b++) begin
            i = (m_l1[g] + b) % 4;
            if (v[4*g + i]) return 4*g + i;
         end
      end
      return -1;
   endfunction

   // One clock cycle: drive, check grant mid-cycle, advance model, check output
   task automatic cyc(input logic [15:0] v, input logic r, input logic rst);
      logic [15:0] exp_g;
      int          w;
      bit          acc;
      reset     = rst;
      i_clreq_v = v;
      o_r       = r;
      acc   = !m_ov || r;
      w     = m_win(v);
      exp_g = '0;
      if (!rst && acc && w >= 0) exp_g[w] = 1'b1;
      #3;
      obs_gnt = i_clreq_r;
      chk_eq("grant", {16'h0, i_clreq_r}, {16'h0, exp_g});
      @(posedge clk);
      #1;
      if (rst) begin
         m_reset();
      end else if (acc) begin
         if (w >= 0) begin
            m_ov = 1'b1;
            m_id = w;
            m_l2 = w / 4;
            m_l1[w/4] = w % 4;
         end else begin
            m_ov = 1'b0;
         end
      end
      chk_eq("o_v", {31'h0, o_v}, {31'h0, m_ov});
      chk_eq("o_clid_req", {28'h0, o_clid_req}, m_id);
   endtask

   initial begin
      logic [15:0] v;
      logic [3:0]  last_id;
      reset     = 1'b1;
      i_clreq_v = '0;
      o_r       = 1'b1;
      m_reset();

      // reset held with requests present: nothing granted, output idle
      for (int k = 0; k < 3; k++) cyc(16'hFFFF, 1'b1, 1'b1);
      chk_eq("reset_ov", {31'h0, o_v}, 32'h0);
      chk_eq("reset_id", {28'h0, o_clid_req}, 32'h0);
      cyc(16'h0000, 1'b1, 1'b0);
      chk_eq("zero_valid_gnt", {16'h0, obs_gnt}, 32'h0);

      // one-hot sweep: single requester wins regardless of pointers
      for (int i = 0; i < 16; i++) begin
         v = '0;
         v[i] = 1'b1;
         cyc(v, 1'b1, 1'b0);
         chk_eq("sweep_gnt", {16'h0, obs_gnt}, {16'h0, v});
         chk_eq("sweep_id", {28'h0, o_clid_req}, i);
         chk_eq("sweep_ov", {31'h0, o_v}, 32'h1);
      end

      cyc(16'h0022, 1'b1, 1'b0);
      chk_eq("pat22_gnt", {16'h0, obs_gnt}, 32'h2);
      chk_eq("pat22_id", {28'h0, o_clid_req}, 32'd1);
      cyc(16'h0006, 1'b1, 1'b0);
      chk_eq("pat06_gnt", {16'h0, obs_gnt}, 32'h4);
      chk_eq("pat06_id", {28'h0, o_clid_req}, 32'd2);
      cyc(16'h0066, 1'b1, 1'b0);
      chk_eq("pat66a_id", {28'h0, o_clid_req}, 32'd5);
      cyc(16'h0066, 1'b1, 1'b0);
      chk_eq("pat66b_id", {28'h0, o_clid_req}, 32'd1);
      cyc(16'hFFFF, 1'b1, 1'b0);
      chk_eq("patFFa_gnt", {16'h0, obs_gnt}, 32'h40);
      cyc(16'hFFFF, 1'b1, 1'b0);
      chk_eq("patFFb_gnt", {16'h0, obs_gnt}, 32'h100);

      // fairness from reset: interleaved across groups
      cyc(16'hFFFF, 1'b1, 1'b1);
      for (int k = 0; k < 16; k++) begin
         cyc(16'hFFFF, 1'b1, 1'b0);
         chk_eq("fair_id", {28'h0, o_clid_req}, (k % 4) * 4 + k / 4);
      end

      // stall: entry and payload held, no grants
      last_id = o_clid_req;
      for (int k = 0; k < 3; k++) begin
         cyc(16'hFFFF, 1'b0, 1'b0);
         chk_eq("stall_gnt", {16'h0, obs_gnt}, 32'h0);
         chk_eq("stall_ov", {31'h0, o_v}, 32'h1);
         chk_eq("stall_id", {28'h0, o_clid_req}, {28'h0, last_id});
      end

      // random traffic with backpressure, sparse/dense valids, rare resets
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
            1: v = 16'($urandom);
            2: v = 16'h1 << $urandom_range(0, 15);
            default: v = 16'($urandom) | 16'($urandom);
         endcase
         cyc(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
